// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   localparam int DIV_WIDTH  = 8;
   localparam int ITER_CNT_W = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      ITER,
      FIX
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, restore on borrow.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH:0]   dvs_mag,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The partial remainder stays below the divisor magnitude, so a WIDTH+1
   // bit difference is enough for the sign bit to signal a borrow.
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      diff     = shifted - dvs_mag;
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH]) begin
         rem_next = diff[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/restoring_divider.sv
// Signed restoring divider driven by the multiplier's button/switch conventions;
// quotient on Bval, remainder on Aval, results chain into the next Run.
module restoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic             ClearA_LoadB,
   input  logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             Busy,
   output logic             DivZero,
   output logic             Ovf
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state_q;
   state_t             state_d;
   logic               run_q;
   logic [WIDTH-1:0]   divisor_q;
   logic [WIDTH:0]     dvs_mag_q;
   logic               dvd_neg_q;
   logic               dvs_neg_q;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               start;
   logic               load;
   logic [WIDTH:0]     dvs_ext;
   logic [WIDTH:0]     dvs_mag;
   logic [WIDTH-1:0]   dvd_mag;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quo_next;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               ovf_case;

   assign start = (state_q == IDLE) && run_q && !Run;
   assign load  = (state_q == IDLE) && !ClearA_LoadB;
   assign Busy  = (state_q != IDLE);

   // The dividend magnitude fits WIDTH unsigned bits even for the most negative value.
   assign dvs_ext  = {divisor_q[WIDTH-1], divisor_q};
   assign dvs_mag  = divisor_q[WIDTH-1] ? (~dvs_ext + (WIDTH+1)'(1)) : dvs_ext;
   assign dvd_mag  = Bval[WIDTH-1] ? (~Bval + WIDTH'(1)) : Bval;

   assign quo_fix  = (dvd_neg_q ^ dvs_neg_q) ? (~quo_q + WIDTH'(1)) : quo_q;
   assign rem_fix  = dvd_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
   assign ovf_case = (Bval == MOST_NEG) && (&divisor_q);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .dvs_mag  (dvs_mag_q),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         run_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         run_q   <= Run;
      end
   end

   // A load in IDLE takes priority and swallows any coincident start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!load && start) state_d = PREP;
         PREP:    state_d = (dvs_mag == '0) ? FIX : ITER;
         ITER:    if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Aval      <= '0;
         Bval      <= '0;
         DivZero   <= 1'b0;
         Ovf       <= 1'b0;
         divisor_q <= '0;
         dvs_mag_q <= '0;
         dvd_neg_q <= 1'b0;
         dvs_neg_q <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load) begin
                  Bval    <= S;
                  Aval    <= '0;
                  DivZero <= 1'b0;
                  Ovf     <= 1'b0;
               end else if (start) begin
                  divisor_q <= S;
                  DivZero   <= 1'b0;
                  Ovf       <= 1'b0;
               end
            end
            PREP: begin
               dvd_neg_q <= Bval[WIDTH-1];
               dvs_neg_q <= divisor_q[WIDTH-1];
               dvs_mag_q <= dvs_mag;
               quo_q     <= dvd_mag;
               rem_q     <= '0;
               cnt_q     <= '0;
               if (dvs_mag == '0) DivZero <= 1'b1;
            end
            ITER: begin
               rem_q <= rem_next;
               quo_q <= quo_next;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            FIX: begin
               // A zero divisor leaves the dividend visible on Aval for diagnosis.
               if (DivZero) begin
                  Bval <= '1;
                  Aval <= Bval;
               end else begin
                  Bval <= quo_fix;
                  Aval <= rem_fix;
                  Ovf  <= ovf_case;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
